// File: rtl/single_two_frac_power_scale.sv
// single_two_frac_power_scale
// Completes the exp2 datapath. It takes the original operand a and
// p = 2^trunc(a) from the integer-power stage, evaluates 2^frac(a) with a
// Horner polynomial on one shared multiplier, and packs the two into 2^a.
// Valid/ready handshake on both sides; latency is fixed at 8 edges from accept.
// NTERMS is the polynomial degree; the coefficient ROM holds c1..c7, so
// NTERMS must lie between 2 and 7.

module single_two_frac_power_scale #(
  parameter int NTERMS = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c
);

  typedef enum logic [2:0] {
    IDLE,
    EXTRACT,
    ITER,
    PACK,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [7:0]  p_exp;
  logic [23:0] g;
  logic [7:0]  eo;
  logic [24:0] acc;
  logic [2:0]  k;

  logic [7:0]  e_a;
  logic [23:0] s_a;
  logic [23:0] f_val;
  logic [48:0] prod;
  logic [25:0] y;
  logic [22:0] mant;
  logic        unused_p;

  // Only the exponent field of p carries information for this stage.
  assign unused_p = ^{p[31], p[22:0]};

  // Coefficient ROM: ck = ln2^k / k!, rounded to nearest Q0.24.
  function automatic logic [24:0] coef(input logic [2:0] idx);
    logic [24:0] v;
    case (idx)
      3'd1:    v = 25'd11629080;
      3'd2:    v = 25'd4030332;
      3'd3:    v = 25'd931204;
      3'd4:    v = 25'd161365;
      3'd5:    v = 25'd22370;
      3'd6:    v = 25'd2584;
      3'd7:    v = 25'd256;
      default: v = 25'd0;
    endcase
    return v;
  endfunction

  // Fractional part of the registered operand as Q0.24; denormals and
  // operands too large to have fraction bits both give zero.
  always_comb begin
    e_a   = a_q[30:23];
    s_a   = {1'b1, a_q[22:0]};
    f_val = '0;
    if (e_a == 8'd0 || e_a >= 8'd150) begin
      f_val = '0;
    end else if (e_a >= 8'd126) begin
      f_val = s_a << (e_a - 8'd126);
    end else begin
      f_val = s_a >> (8'd126 - e_a);
    end
  end

  // One 24x25 multiplier, shared by the Horner steps and the final pack.
  assign prod = {24'd0, acc} * {25'd0, g};

  // Final Q1.24 value of 2^G and its mantissa, saturated at the top end.
  always_comb begin
    y    = 26'h1000000 + {1'b0, prod[48:24]};
    mant = y[23:1];
    if (y >= 26'h2000000) begin
      mant = 23'h7FFFFF;
    end
  end

  // Control and datapath sequencing: accept, extract, iterate, pack, hand off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      a_q       <= '0;
      p_exp     <= '0;
      g         <= '0;
      eo        <= '0;
      acc       <= '0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            p_exp    <= p[30:23];
            in_ready <= 1'b0;
            state    <= EXTRACT;
          end
        end
        EXTRACT: begin
          // Negative operands borrow one from the integer part so the
          // polynomial always sees a fraction in [0,1).
          if (!a_q[31] || f_val == 24'd0) begin
            g  <= f_val;
            eo <= p_exp;
          end else begin
            g  <= 24'd0 - f_val;
            eo <= p_exp - 8'd1;
          end
          acc   <= coef(3'(NTERMS));
          k     <= 3'(NTERMS - 1);
          state <= ITER;
        end
        ITER: begin
          acc <= coef(k) + prod[48:24];
          k   <= k - 3'd1;
          if (k == 3'd1) begin
            state <= PACK;
          end
        end
        PACK: begin
          if (p_exp == 8'd0) begin
            c <= '0;
          end else begin
            c <= {1'b0, eo, mant};
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
